add_seq: RTL and testbench
==========================

# add_seq

Parametrised multi-cycle adder/subtractor, successor to the fixed 16-bit `add_16`. It processes a WIDTH-bit operation in CHUNK-bit slices, least significant slice first, one slice per clock, with a registered carry between slices. Operands arrive through a valid/ready input handshake, and results leave through a valid/ready output handshake. It sits between the operand register file and the ALU result bus wherever a narrow carry chain is required to meet timing.

## Interface
- WIDTH, 32: operand and result width. Must be an integer multiple of CHUNK.
- CHUNK, 8: bits processed per cycle. NCHUNK = WIDTH/CHUNK, and NCHUNK ≥ 1.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and mode valid.
- in_ready  out  1  block can accept a new operation.
- SUB  in  1  0 = OP_A + OP_B + CYI; 1 = OP_A + ~OP_B + CYI. For plain subtraction, CYI = 1.
- CYI  in  1  carry in.
- OP_A  in  WIDTH  operand A.
- OP_B  in  WIDTH  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- CYO  out  1  carry out of the MSB. For subtraction, 0 means a borrow occurred.
- OVF  out  1  two's-complement signed overflow.
- SUM  out  WIDTH  result.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE**
  - in_ready = 1.
  - On in_valid && in_ready, latch OP_A and the effective B (B' = SUB ? ~OP_B : OP_B) into working registers, load carry_r = CYI, clear slice counter cnt to 0, and go to RUN.
- **RUN**
  - Each cycle, slice cnt computes {c, s} = A[cnt] + B'[cnt] + carry_r.
  - s is written into SUM slice cnt, and carry_r <= c.
  - When cnt == NCHUNK-1:
    - CYO <= c.
    - OVF <= (A[MSB] == B'[MSB]) && (s[MSB] != A[MSB]).
    - out_valid <= 1.
    - Go to DONE.
  - Otherwise cnt <= cnt + 1.
- **DONE**
  - SUM, CYO and OVF hold stable while out_valid = 1.
  - On out_valid && out_ready, clear out_valid and return to IDLE.
  - No new operation is accepted in the same cycle.
- in_ready = 0 in RUN and DONE. in_valid is ignored there and operands are not sampled.
- Input operands need only be stable in the handshake cycle; the block works from its internal copies.
- Only the full result is defined. SUM slices not yet written in RUN are undefined, so consumers use SUM only while out_valid = 1.
- When NCHUNK = 1, RUN lasts one cycle and cnt is a 1-bit tie-off.

## Timing
- Reset: while rst_n is low and immediately on its falling edge:
  - state = IDLE.
  - in_ready = 1, out_valid = 0.
  - SUM = 0, CYO = 0, OVF = 0, cnt = 0, carry_r = 0.
- Reset mid-RUN or mid-DONE abandons the operation without emitting a result.
- Latency: input handshake at edge k gives out_valid high after edge k+NCHUNK.
- Throughput: one operation per NCHUNK+2 cycles when out_ready is held high.
- out_valid, SUM, CYO, OVF and in_ready are all registered outputs.
- Backpressure: out_ready low holds DONE indefinitely with outputs unchanged.
- Counter: cnt has width max(1, $clog2(NCHUNK)) and never exceeds NCHUNK-1. It does not wrap during RUN.

## Structure
- Package add_pkg holds:
  - typedef enum logic [1:0] add_state_t {IDLE, RUN, DONE}.
  - The function that derives NCHUNK and the counter width.
- Sub-module add_slice: combinational CHUNK-bit adder.
  - Ports: cin, a[CHUNK], b[CHUNK], s[CHUNK], cout.
  - add_seq instantiates it once and muxes operand slices by cnt.
- add_seq holds the FSM, operand registers, carry register and output registers.

## Test plan
- WIDTH=32, CHUNK=8, SUB=0, CYI=0, OP_A=0x1111_1111, OP_B=0x1111_1111 -> SUM=0x2222_2222, CYO=0, OVF=0. out_valid rises exactly 4 cycles after the handshake.
- Full ripple: OP_A=0xFFFF_FFFF, OP_B=0, CYI=1, SUB=0 -> SUM=0x0000_0000, CYO=1, OVF=0.
- Signed overflow: OP_A=0x7FFF_FFFF, OP_B=1, CYI=0 -> SUM=0x8000_0000, CYO=0, OVF=1.
- Subtract:
  - SUB=1, CYI=1, A=0x1234, B=0x1111 -> SUM=0x0000_0123, CYO=1.
  - A=5, B=7 -> SUM=0xFFFF_FFFE, CYO=0, OVF=0.
- Backpressure and reset:
  - Hold out_ready low 5 cycles in DONE while toggling in_valid -> SUM, out_valid, CYO and OVF are stable, and in_ready=0.
  - Raise out_ready -> IDLE next cycle.
  - Assert rst_n low at cnt=1 of a new op -> all outputs go to reset values at once.
  - After release, the next operation is correct.
- WIDTH=16, CHUNK=16: OP_A=0x1111, OP_B=0x1234, CYI=1 -> SUM=0x2346, CYO=0, with out_valid 1 cycle after the handshake.

Source files
------------

// File: rtl/add_pkg.sv
// Shared types and elaboration helpers for the multi-cycle adder/subtractor.
package add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } add_state_t;

  // Number of CHUNK-bit slices that make up one WIDTH-bit operand.
  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Slice counter width; a single-slice build still keeps a 1-bit tie-off.
  function automatic int cnt_width(input int width, input int chunk);
    int n;
    n = width / chunk;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add_slice.sv
// Combinational CHUNK-bit adder slice with carry in and carry out.
module add_slice #(
  parameter int CHUNK = 8
) (
  input  logic             cin,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/add_seq.sv
// Multi-cycle WIDTH-bit adder/subtractor: one CHUNK-bit slice per clock,
// least significant slice first, carry registered between slices.
module add_seq
  import add_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             SUB,
  input  logic             CYI,
  input  logic [WIDTH-1:0] OP_A,
  input  logic [WIDTH-1:0] OP_B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             CYO,
  output logic             OVF,
  output logic [WIDTH-1:0] SUM
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int CNT_W  = cnt_width(WIDTH, CHUNK);
  localparam int SH_W   = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}});

  add_state_t       state, next_state;
  logic [WIDTH-1:0] a_r, b_r;
  logic             carry_r;
  logic [CNT_W-1:0] cnt;
  logic [SH_W-1:0]  shamt;
  logic [CHUNK-1:0] a_s, b_s, s;
  logic             c;
  logic             last;
  logic             accept;

  assign accept = (state == IDLE) && in_valid && in_ready;
  assign last   = (cnt == LAST);

  // Bit offset of the active slice; the operand slices are picked by shifting.
  assign shamt = SH_W'(cnt) * SH_W'(CHUNK);
  assign a_s   = CHUNK'(a_r >> shamt);
  assign b_s   = CHUNK'(b_r >> shamt);

  add_slice #(
    .CHUNK(CHUNK)
  ) u_slice (
    .cin (carry_r),
    .a   (a_s),
    .b   (b_s),
    .s   (s),
    .cout(c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid && in_ready) next_state = RUN;
      RUN:     if (last) next_state = DONE;
      DONE:    if (out_valid && out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand copies (B already inverted for subtraction); only loaded on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_r <= OP_A;
      b_r <= SUB ? ~OP_B : OP_B;
    end
  end

  // Slice sequencing, carry chain and registered result/handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_r   <= 1'b0;
      cnt       <= '0;
      SUM       <= '0;
      CYO       <= 1'b0;
      OVF       <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            carry_r  <= CYI;
            cnt      <= '0;
            in_ready <= 1'b0;
          end
        end
        RUN: begin
          SUM     <= (SUM & ~(SLICE_MASK << shamt)) | (WIDTH'(s) << shamt);
          carry_r <= c;
          if (last) begin
            CYO       <= c;
            // Overflow: operands share a sign that the result does not.
            OVF       <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (s[CHUNK-1] != a_r[WIDTH-1]);
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_add_seq.sv
// Self-checking bench for add_seq: 32/8 build (table + scoreboard) and 16/16 build.
module tb_add_seq;

  typedef struct packed {
    logic [31:0] sum;
    logic        cyo;
    logic        ovf;
  } exp_t;

  typedef struct packed {
    logic        s;
    logic        c;
    logic [31:0] a;
    logic [31:0] b;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 32-bit, 8-bit slice instance
  logic        in_valid = 1'b0, in_ready, sub = 1'b0, cyi = 1'b0;
  logic [31:0] op_a = '0, op_b = '0, sum;
  logic        out_valid, out_ready = 1'b1, cyo, ovf;

  // 16-bit, single slice instance
  logic        in_valid_w = 1'b0, in_ready_w, sub_w = 1'b0, cyi_w = 1'b0;
  logic [15:0] op_a_w = '0, op_b_w = '0, sum_w;
  logic        out_valid_w, out_ready_w = 1'b1, cyo_w, ovf_w;

  add_seq #(.WIDTH(32), .CHUNK(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .SUB(sub), .CYI(cyi), .OP_A(op_a), .OP_B(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .CYO(cyo), .OVF(ovf), .SUM(sum)
  );

  add_seq #(.WIDTH(16), .CHUNK(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .SUB(sub_w), .CYI(cyi_w), .OP_A(op_a_w), .OP_B(op_b_w),
    .out_valid(out_valid_w), .out_ready(out_ready_w), .CYO(cyo_w), .OVF(ovf_w), .SUM(sum_w)
  );

  int   checks = 0;
  int   errors = 0;
  int   hs_cyc = 0;
  exp_t sb[$];
  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic s, input logic c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] bb;
    logic [32:0] t;
    exp_t        e;
    bb    = s ? ~b : b;
    t     = {1'b0, a} + {1'b0, bb} + {32'b0, c};
    e.sum = t[31:0];
    e.cyo = t[32];
    e.ovf = (a[31] == bb[31]) && (t[31] != a[31]);
    return e;
  endfunction

  function automatic vec_t mk(input logic s, input logic c, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] r, input logic co, input logic ov);
    vec_t v;
    v.s = s; v.c = c; v.a = a; v.b = b;
    v.e.sum = r; v.e.cyo = co; v.e.ovf = ov;
    return v;
  endfunction

  // Drive one operation into dut0, wait for the handshake, push its expectation.
  task automatic send(input logic s, input logic c, input logic [31:0] a, input logic [31:0] b, input exp_t e);
    int n;
    @(negedge clk);
    sub = s; cyi = c; op_a = a; op_b = b; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_hs", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    hs_cyc   = cyc;
    in_valid = 1'b0;
    op_a = $urandom; op_b = $urandom; sub = 1'($urandom); cyi = 1'($urandom);
    sb.push_back(e);
  endtask

  // Count edges from the handshake until out_valid appears (bounded).
  task automatic wait_out(input int exp_lat);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", 32'(n), 32'(exp_lat));
  endtask

  // Pop the oldest expectation and compare against the presented result.
  task automatic cmp_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard_empty actual=0 expected=1", tag);
      return;
    end
    e = sb.pop_front();
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sum"},   sum,            e.sum);
    check({tag, "_cyo"},   32'(cyo),       32'(e.cyo));
    check({tag, "_ovf"},   32'(ovf),       32'(e.ovf));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t bp;
    int   prev_hs;

    tbl[0] = mk(0, 0, 32'h1111_1111, 32'h1111_1111, 32'h2222_2222, 0, 0);
    tbl[1] = mk(0, 1, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1, 0);
    tbl[2] = mk(0, 0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 1);
    tbl[3] = mk(1, 1, 32'h0000_1234, 32'h0000_1111, 32'h0000_0123, 1, 0);
    tbl[4] = mk(1, 1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 0, 0);
    tbl[5] = mk(1, 1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1, 1);
    for (int i = 6; i < 12; i++) begin
      tbl[i].s = 1'($urandom);
      tbl[i].c = 1'($urandom);
      tbl[i].a = $urandom;
      tbl[i].b = $urandom;
      tbl[i].e = model(tbl[i].s, tbl[i].c, tbl[i].a, tbl[i].b);
    end

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum",       sum,            32'd0);
    check("rst_cyo",       32'(cyo),       32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);
    check("rst_w_valid",   32'(out_valid_w), 32'd0);
    check("rst_w_ready",   32'(in_ready_w),  32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-slice build: result one edge after the handshake
    @(negedge clk);
    out_ready_w = 1'b0;
    op_a_w = 16'h1111; op_b_w = 16'h1234; cyi_w = 1'b1; sub_w = 1'b0; in_valid_w = 1'b1;
    @(posedge clk);
    #1;
    in_valid_w = 1'b0;
    check("w_valid_hs",  32'(out_valid_w), 32'd0);
    check("w_ready_hs",  32'(in_ready_w),  32'd0);
    @(posedge clk);
    #1;
    check("w_valid", 32'(out_valid_w), 32'd1);
    check("w_sum",   32'(sum_w),       32'h2346);
    check("w_cyo",   32'(cyo_w),       32'd0);
    check("w_ovf",   32'(ovf_w),       32'd0);
    out_ready_w = 1'b1;
    @(posedge clk);
    #1;
    check("w_idle_valid", 32'(out_valid_w), 32'd0);
    check("w_idle_ready", 32'(in_ready_w),  32'd1);
    @(negedge clk);
    op_a_w = 16'h0005; op_b_w = 16'h0007; cyi_w = 1'b1; sub_w = 1'b1; in_valid_w = 1'b1;
    @(posedge clk);
    #1;
    in_valid_w = 1'b0;
    @(posedge clk);
    #1;
    check("w_sub_sum", 32'(sum_w), 32'hFFFE);
    check("w_sub_cyo", 32'(cyo_w), 32'd0);
    @(posedge clk);
    #1;

    // Table of operations through the scoreboard, out_ready held high
    out_ready = 1'b1;
    prev_hs = 0;
    for (int i = 0; i < 12; i++) begin
      send(tbl[i].s, tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].e);
      if (i > 0) check("throughput", 32'(hs_cyc - prev_hs), 32'd6);
      prev_hs = hs_cyc;
      wait_out(4);
      cmp_out($sformatf("vec%0d", i));
      @(posedge clk);
      #1;
      check("accept_valid", 32'(out_valid), 32'd0);
      check("accept_ready", 32'(in_ready),  32'd1);
    end

    // Backpressure: DONE held with outputs frozen while in_valid toggles
    @(negedge clk);
    out_ready = 1'b0;
    send(0, 0, 32'h8000_0001, 32'h8000_0001, model(0, 0, 32'h8000_0001, 32'h8000_0001));
    wait_out(4);
    bp = sb[0];
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      op_a = $urandom; op_b = $urandom;
      @(posedge clk);
      #1;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_sum",   sum,            bp.sum);
      check("bp_cyo",   32'(cyo),       32'(bp.cyo));
      check("bp_ovf",   32'(ovf),       32'(bp.ovf));
      check("bp_ready", 32'(in_ready),  32'd0);
    end
    cmp_out("bp");
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready),  32'd1);

    // Reset in the middle of RUN abandons the operation
    send(0, 0, 32'h0102_0304, 32'h1020_3040, model(0, 0, 32'h0102_0304, 32'h1020_3040));
    @(posedge clk);
    #1;
    check("mid_cnt", 32'(dut0.cnt), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready),  32'd1);
    check("mid_rst_sum",   sum,            32'd0);
    check("mid_rst_cyo",   32'(cyo),       32'd0);
    check("mid_rst_ovf",   32'(ovf),       32'd0);
    check("mid_rst_cnt",   32'(dut0.cnt),  32'd0);
    void'(sb.pop_front());
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check("post_rst_no_valid", 32'(out_valid), 32'd0);
    end
    send(1, 1, 32'hDEAD_BEEF, 32'h0BAD_F00D, model(1, 1, 32'hDEAD_BEEF, 32'h0BAD_F00D));
    wait_out(4);
    cmp_out("post_rst");
    @(posedge clk);
    #1;
    check("post_rst_idle", 32'(in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
